// File: rtl/multicycle_datapath.sv
// multicycle_datapath
// Multi-cycle MIPS-style datapath. One instruction is accepted over a
// valid/ready handshake and stepped through IDLE -> DECODE -> EXEC -> MEM -> WB.
// Supported: R-type add/sub/and/or/slt/nor, addi, lw, sw, beq.
// Ports:
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   instr        instruction word, captured on acceptance
//   instr_valid  instr is presented
//   instr_ready  idle, an instruction can be accepted
//   DS           result of the last retired instruction
//   done         one-cycle retirement pulse
//   branch_taken beq condition result, valid with done
//   zero_flag    ALU zero result of the last EXEC, held
//   illegal      unsupported opcode/funct, valid with done
module multicycle_datapath #(
    parameter int DATA_W    = 32,
    parameter int REG_DEPTH = 32,
    parameter int MEM_DEPTH = 128
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] DS,
    output logic              done,
    output logic              branch_taken,
    output logic              zero_flag,
    output logic              illegal
);
    localparam int REG_AW = $clog2(REG_DEPTH);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    logic [2:0]        state_r, state_nxt_s;
    logic [31:0]       ir_r;
    logic [DATA_W-1:0] a_r, b_r, alu_out_r, mdr_r, ds_r;
    logic              done_r, branch_taken_r, zero_flag_r, illegal_r;
    logic [DATA_W-1:0] rf_r [REG_DEPTH];
    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    logic [5:0]        op_s, funct_s;
    logic [REG_AW-1:0] rs_s, rt_s, rd_s, wb_dest_s;
    logic [DATA_W-1:0] imm_s, alu_s, wb_data_s, mem_rdata_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic              is_rtype_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s;
    logic              funct_ok_s, legal_s, mem_we_s, rf_we_s;
    logic              unused_s;

    // Field extraction from the latched instruction register
    assign op_s     = ir_r[31:26];
    assign funct_s  = ir_r[5:0];
    assign rs_s     = ir_r[21 +: REG_AW];
    assign rt_s     = ir_r[16 +: REG_AW];
    assign rd_s     = ir_r[11 +: REG_AW];
    assign imm_s    = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
    // Word address taken from the byte address in ALU-out, wrapping on depth
    assign mem_idx_s   = alu_out_r[MEM_AW+1:2];
    assign mem_rdata_s = mem_r[mem_idx_s];
    // Shamt and the sub-word / out-of-range address bits carry no meaning here
    assign unused_s = ^{ir_r[10:6], alu_out_r[1:0], alu_out_r[DATA_W-1:MEM_AW+2]};

    assign instr_ready  = (state_r == IDLE);
    assign DS           = ds_r;
    assign done         = done_r;
    assign branch_taken = branch_taken_r;
    assign zero_flag    = zero_flag_r;
    assign illegal      = illegal_r;

    // Opcode/funct classification and legality
    always_comb begin
        is_rtype_s = (op_s == OP_RTYPE);
        is_addi_s  = (op_s == OP_ADDI);
        is_lw_s    = (op_s == OP_LW);
        is_sw_s    = (op_s == OP_SW);
        is_beq_s   = (op_s == OP_BEQ);
        case (funct_s)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: funct_ok_s = 1'b1;
            default:                                       funct_ok_s = 1'b0;
        endcase
        legal_s = (is_rtype_s && funct_ok_s) || is_addi_s || is_lw_s ||
                  is_sw_s || is_beq_s;
    end

    // ALU: R-type by funct, beq compares by subtraction, others add the offset
    always_comb begin
        alu_s = '0;
        if (is_rtype_s) begin
            case (funct_s)
                FN_ADD:  alu_s = a_r + b_r;
                FN_SUB:  alu_s = a_r - b_r;
                FN_AND:  alu_s = a_r & b_r;
                FN_OR:   alu_s = a_r | b_r;
                FN_SLT:  alu_s = ($signed(a_r) < $signed(b_r)) ?
                                 {{(DATA_W-1){1'b0}}, 1'b1} : '0;
                FN_NOR:  alu_s = ~(a_r | b_r);
                default: alu_s = '0;
            endcase
        end else if (is_beq_s) begin
            alu_s = a_r - b_r;
        end else begin
            alu_s = a_r + imm_s;
        end
    end

    // Writeback destination/data and write enables
    always_comb begin
        wb_dest_s = is_rtype_s ? rd_s : rt_s;
        wb_data_s = is_lw_s ? mdr_r : alu_out_r;
        mem_we_s  = (state_r == MEM) && is_sw_s;
        rf_we_s   = (state_r == WB) && (wb_dest_s != '0);
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = instr_valid ? DECODE : IDLE;
            DECODE:  state_nxt_s = legal_s ? EXEC : IDLE;
            EXEC:    begin
                if (is_beq_s) begin
                    state_nxt_s = IDLE;
                end else if (is_lw_s || is_sw_s) begin
                    state_nxt_s = MEM;
                end else begin
                    state_nxt_s = WB;
                end
            end
            MEM:     state_nxt_s = is_sw_s ? IDLE : WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer, pipeline registers and retirement outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r        <= IDLE;
            ir_r           <= 32'd0;
            a_r            <= '0;
            b_r            <= '0;
            alu_out_r      <= '0;
            mdr_r          <= '0;
            ds_r           <= '0;
            done_r         <= 1'b0;
            branch_taken_r <= 1'b0;
            zero_flag_r    <= 1'b0;
            illegal_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (instr_valid) ir_r <= instr;
                end
                DECODE: begin
                    a_r <= rf_r[rs_s];
                    b_r <= rf_r[rt_s];
                    if (!legal_s) begin
                        done_r         <= 1'b1;
                        illegal_r      <= 1'b1;
                        branch_taken_r <= 1'b0;
                    end
                end
                EXEC: begin
                    alu_out_r   <= alu_s;
                    zero_flag_r <= (alu_s == '0);
                    if (is_beq_s) begin
                        done_r         <= 1'b1;
                        branch_taken_r <= (alu_s == '0);
                        illegal_r      <= 1'b0;
                        ds_r           <= imm_s;
                    end
                end
                MEM: begin
                    if (is_sw_s) begin
                        done_r         <= 1'b1;
                        branch_taken_r <= 1'b0;
                        illegal_r      <= 1'b0;
                        ds_r           <= b_r;
                    end else begin
                        mdr_r <= mem_rdata_s;
                    end
                end
                WB: begin
                    done_r         <= 1'b1;
                    branch_taken_r <= 1'b0;
                    illegal_r      <= 1'b0;
                    ds_r           <= wb_data_s;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Register file; entry 0 is never written so it always reads zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < REG_DEPTH; i++) rf_r[i] <= '0;
        end else if (rf_we_s) begin
            rf_r[wb_dest_s] <= wb_data_s;
        end
    end

    // Data memory, intentionally not reset; reset forces IDLE so no write follows
    always_ff @(posedge CLK) begin
        if (mem_we_s) mem_r[mem_idx_s] <= b_r;
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] DS;
    logic        done, branch_taken, zero_flag, illegal;

    int tests = 0;
    int fails = 0;

    multicycle_datapath #(.DATA_W(32), .REG_DEPTH(32), .MEM_DEPTH(128)) dut (
        .CLK(CLK), .RST_N(RST_N), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .DS(DS), .done(done),
        .branch_taken(branch_taken), .zero_flag(zero_flag), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          lat;
        logic [31:0] ds;
        logic        bt;
        logic        ill;
        logic        zf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction and measure edges from the accept edge to done
    task automatic run_instr(input logic [31:0] ins, output int lat);
        int w;
        @(negedge CLK);
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge CLK);
            w++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n_done;

        // r1=5 r2=7 r3=12 preloaded, memory word 2 = 12 then 99 via wrapped address
        vecs.push_back('{"addi_r1",   enc_i(6'b001000, 5'd0, 5'd1, 16'd5),  4, 32'd5,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"addi_r2",   enc_i(6'b001000, 5'd0, 5'd2, 16'd7),  4, 32'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"add_r3",    enc_r(5'd1, 5'd2, 5'd3, 6'b100000),   4, 32'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_r4",    enc_r(5'd1, 5'd1, 5'd4, 6'b100010),   4, 32'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{"slt_r5",    enc_r(5'd1, 5'd2, 5'd5, 6'b101010),   4, 32'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"nor_r6",    enc_r(5'd0, 5'd0, 5'd6, 6'b100111),   4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"and_r7",    enc_r(5'd1, 5'd2, 5'd7, 6'b100100),   4, 32'd5,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or_r7",     enc_r(5'd1, 5'd2, 5'd7, 6'b100101),   4, 32'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sw_8",      enc_i(6'b101011, 5'd0, 5'd3, 16'd8),  4, 32'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lw_8",      enc_i(6'b100011, 5'd0, 5'd7, 16'd8),  5, 32'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"addi_r8",   enc_i(6'b001000, 5'd0, 5'd8, 16'd99), 4, 32'd99, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sw_wrap",   enc_i(6'b101011, 5'd0, 5'd8, 16'd520),4, 32'd99, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lw_wrap",   enc_i(6'b100011, 5'd0, 5'd9, 16'd8),  5, 32'd99, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"beq_taken", enc_i(6'b000100, 5'd1, 5'd1, 16'hFFFD), 3, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"beq_not",   enc_i(6'b000100, 5'd1, 5'd2, 16'd4),  3, 32'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"regs_kept", enc_r(5'd1, 5'd2, 5'd11, 6'b100000),  4, 32'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"beq_again", enc_i(6'b000100, 5'd1, 5'd2, 16'd4),  3, 32'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"ill_op",    {6'b111111, 26'd0},                   2, 32'd4,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{"ill_funct", enc_r(5'd1, 5'd2, 5'd3, 6'b000001),   2, 32'd4,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{"r3_kept",   enc_r(5'd3, 5'd0, 5'd12, 6'b100000),  4, 32'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"addi_r0",   enc_i(6'b001000, 5'd0, 5'd0, 16'd9),  4, 32'd9,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"r0_zero",   enc_r(5'd0, 5'd0, 5'd10, 6'b100000),  4, 32'd0,  1'b0, 1'b0, 1'b1});

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_ds", DS, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bt", {31'd0, branch_taken}, 32'd0);
        check("rst_zero", {31'd0, zero_flag}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].ins, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_ds"}, DS, vecs[i].ds);
            check({vecs[i].name, "_bt"}, {31'd0, branch_taken}, {31'd0, vecs[i].bt});
            check({vecs[i].name, "_ill"}, {31'd0, illegal}, {31'd0, vecs[i].ill});
            check({vecs[i].name, "_zero"}, {31'd0, zero_flag}, {31'd0, vecs[i].zf});
        end

        // instr_valid held while busy: only the first instruction retires
        @(negedge CLK);
        instr = enc_i(6'b001000, 5'd0, 5'd1, 16'd3);
        instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr = enc_i(6'b001000, 5'd0, 5'd1, 16'd77);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        instr_valid = 1'b0;
        check("hold_lat", lat, 32'd4);
        check("hold_ds", DS, 32'd3);
        n_done = 0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            if (done) n_done++;
        end
        check("hold_extra_done", n_done, 32'd0);

        // Reset pulled in the MEM state of lw: abort, no done, registers cleared
        @(negedge CLK);
        instr = enc_i(6'b100011, 5'd0, 5'd13, 16'd8);
        instr_valid = 1'b1;
        @(posedge CLK);        // accept -> DECODE
        #1;
        instr_valid = 1'b0;
        @(posedge CLK);        // EXEC
        @(posedge CLK);        // MEM
        #1;
        check("mid_busy", {31'd0, instr_ready}, 32'd0);
        RST_N = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst_ds", DS, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        n_done = 0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (done) n_done++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (done) n_done++;
        end
        check("mid_rst_no_done", n_done, 32'd0);
        run_instr(enc_r(5'd13, 5'd0, 5'd14, 6'b100000), lat);
        check("mid_rst_r13", DS, 32'd0);
        run_instr(enc_r(5'd7, 5'd0, 5'd15, 6'b100000), lat);
        check("mid_rst_r7", DS, 32'd0);
        // Memory survives reset
        run_instr(enc_i(6'b100011, 5'd0, 5'd16, 16'd8), lat);
        check("mem_kept_lat", lat, 32'd5);
        check("mem_kept_ds", DS, 32'd99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle R-type datapath. It accepts one MIPS-style instruction at a time over a valid/ready handshake and sequences it through decode, execute, memory and writeback states. All register-file and data-memory writes are clocked. It supports R-type ALU ops, addi, lw, sw and beq, and reports the result, branch decision and illegal-opcode status per instruction.

## Interface
- DATA_W, 32: datapath width; register file, ALU, memory words and DS.
- REG_DEPTH, 32: register count; the register index is the low log2(REG_DEPTH) bits of the 5-bit field.
- MEM_DEPTH, 128: data-memory words (power of two).
- CLK  in  1  single clock; rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word; sampled on acceptance.
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  block is idle and can accept an instruction.
- DS  out  DATA_W  result of the last retired instruction.
- done  out  1  one-cycle pulse when an instruction retires.
- branch_taken  out  1  valid with done; 1 = beq condition true.
- zero_flag  out  1  ALU zero result of the last EXEC; held.
- illegal  out  1  valid with done; unsupported opcode or funct.

## Operation
- Encoding:
  - op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - imm = [15:0], sign-extended to DATA_W.
- R-type (op 000000), by funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt (signed; result 1 or 0)
  - 100111 nor
  - Writes rd.
- I-type:
  - addi (001000): rt = rs + imm.
  - lw (100011): rt = mem[rs + imm].
  - sw (101011): mem[rs + imm] = rt.
  - beq (000100): branch_taken = (rs - rt == 0). No register write. DS = sign-extended imm, the branch offset.
- Arithmetic is modulo 2^DATA_W; overflow is ignored.
- Memory index = ((rs + imm) >> 2) mod MEM_DEPTH (word addressed, wraps).
- Register 0 always reads 0; writes to it are discarded.
- Instruction register, A/B operand registers, ALU-out register and MDR are all clocked.
- On illegal opcode or funct, no register or memory write occurs; DS holds its previous value.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
  - IDLE: instr_ready = 1. On instr_valid, latch instr and go to DECODE.
  - DECODE: read rs/rt into A/B. Illegal instructions go to IDLE with done and illegal set.
  - EXEC: ALU result and zero_flag registered.
    - beq: go to IDLE.
    - lw/sw: go to MEM.
    - otherwise: go to WB.
  - MEM: sw writes memory and goes to IDLE; lw latches MDR and goes to WB.
  - WB: write the register file, update DS, go to IDLE.
- done is asserted on the cycle the FSM is back in IDLE after retirement.
- DS updates for R-type, addi, lw, sw and beq. For sw, DS = the stored data.

## Timing
- Reset (asynchronous, RST_N low):
  - FSM goes to IDLE.
  - instr_ready = 1.
  - DS = 0, done = 0, branch_taken = 0, zero_flag = 0, illegal = 0.
  - All registers are cleared to 0.
  - Data memory is not reset.
- Latency from the accept edge to the done pulse:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - illegal: 2 cycles.
- Acceptance only when instr_valid && instr_ready on a rising edge. instr_valid while busy is ignored, not queued.
- instr_ready rises in the same cycle done pulses, so back-to-back accept is allowed.
- Register write occurs at the end of WB. A following instruction reading that register sees the new value, since its DECODE is at least 2 cycles later.
- A memory write in MEM is visible to a later lw.
- RST_N asserted mid-instruction aborts it: no pending write completes and no done is produced.

## Test plan
- Reset, then add with r1=5, r2=7 preloaded via addi: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> done after 4 cycles, DS=12, zero_flag=0.
- sub r4,r1,r1 -> DS=0, zero_flag=1. Then slt r5,r1,r2 -> DS=1. Then nor r6,r0,r0 -> DS=0xFFFFFFFF.
- sw r3,8(r0), then lw r7,8(r0) -> sw done at 4 cycles, lw done at 5 cycles with DS=12. Then sw to address 8+4*MEM_DEPTH and lw 8(r0) -> value overwritten (wrap).
- beq r1,r1,-3 -> done at 3 cycles, branch_taken=1, DS=0xFFFFFFFD. beq r1,r2 -> branch_taken=0. No register changed.
- Illegal op 111111, then funct 000001 -> done at 2 cycles, illegal=1, DS unchanged. addi r0,r0,9 -> r0 still reads 0.
- Pull RST_N low in the MEM state of lw -> outputs go to reset values immediately, no done, target register reads 0. Hold instr_valid high while busy -> only one instruction is retired.
